// File: rtl/lram_pkg.sv
// lram_pkg: shared definitions for the lram_arb local work-RAM slice.
//   GNT_NONE / GNT_CORE / GNT_HOST : arbiter grant encoding
//   byte_lanes()                   : number of byte lanes in a data word
package lram_pkg;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_CORE = 2'd1;
  localparam logic [1:0] GNT_HOST = 2'd2;

  function automatic int byte_lanes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/lram_arb_if.sv
// lram_arb_if: request/response bus of both requesters of lram_arb.
//   c_* : core port   (req, we, addr, be, wdata -> ack, rdata, rvalid)
//   h_* : host port   (same, plus h_oe drive enable for the host data bus)
//   oob_err : sticky out-of-range access flag
// modport master : requester side (drives requests, observes responses)
// modport slave  : RAM side (observes requests, drives responses)
interface lram_arb_if
  import lram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);

  localparam int BE_W = byte_lanes(DATA_W);

  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [BE_W-1:0]   c_be;
  logic [DATA_W-1:0] c_wdata;
  logic              c_ack;
  logic [DATA_W-1:0] c_rdata;
  logic              c_rvalid;

  logic              h_req;
  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [BE_W-1:0]   h_be;
  logic [DATA_W-1:0] h_wdata;
  logic              h_ack;
  logic [DATA_W-1:0] h_rdata;
  logic [DATA_W-1:0] h_oe;
  logic              h_rvalid;

  logic              oob_err;

  modport master (
    output c_req, c_we, c_addr, c_be, c_wdata,
    input  c_ack, c_rdata, c_rvalid,
    output h_req, h_we, h_addr, h_be, h_wdata,
    input  h_ack, h_rdata, h_oe, h_rvalid,
    input  oob_err
  );

  modport slave (
    input  c_req, c_we, c_addr, c_be, c_wdata,
    output c_ack, c_rdata, c_rvalid,
    input  h_req, h_we, h_addr, h_be, h_wdata,
    output h_ack, h_rdata, h_oe, h_rvalid,
    output oob_err
  );

endinterface

// File: rtl/lram_array.sv
// lram_array: synchronous single-port RAM with byte-lane write enables.
//   clk : clock
//   cs  : chip select; nothing happens without it
//   we  : 1 = write the enabled lanes of d to word a, 0 = read word a into q
//   be  : byte-lane enables (write only)
//   a   : word address (caller guarantees a < DEPTH whenever cs is high)
//   d   : write data
//   q   : read data, registered, holds until the next read
// Storage has no reset so it maps onto block RAM.
module lram_array
  import lram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic                          clk,
  input  logic                          cs,
  input  logic                          we,
  input  logic [byte_lanes(DATA_W)-1:0] be,
  input  logic [ADDR_W-1:0]             a,
  input  logic [DATA_W-1:0]             d,
  output logic [DATA_W-1:0]             q
);

  localparam int BE_W = byte_lanes(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) mem[a][8*i +: 8] <= d[8*i +: 8];
        end
      end else begin
        q <= mem[a];
      end
    end
  end

endmodule

// File: rtl/lram_arb.sv
// lram_arb: local work RAM shared by the processor core and the host bus.
//   sys_clk : clock, all state changes on the rising edge
//   resetl  : asynchronous active-low reset
//   bus     : lram_arb_if slave modport carrying both request ports,
//             acks, read data/valid, host output enable and oob_err
// The core wins ties, but after STARVE_MAX consecutive core grants with
// the host waiting, the host is forced through for one access.
module lram_arb
  import lram_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int DEPTH      = 1024,
  parameter int STARVE_MAX = 4
) (
  input  logic     sys_clk,
  input  logic     resetl,
  lram_arb_if.slave bus
);

  localparam int BE_W  = byte_lanes(DATA_W);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [1:0]        gnt;
  logic [CNT_W-1:0]  starve_cnt;
  logic              host_sel;
  logic              access;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic [31:0]       sel_addr_ext;
  logic              in_range;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] rd_word;
  logic              rd_zero;
  logic              c_rvalid_r;
  logic              h_rvalid_r;
  logic [DATA_W-1:0] c_hold;
  logic [DATA_W-1:0] h_hold;
  logic              oob_r;

  always_comb begin
    gnt = GNT_NONE;
    if (bus.c_req && bus.h_req) begin
      gnt = (starve_cnt < STARVE_LIM) ? GNT_CORE : GNT_HOST;
    end else if (bus.c_req) begin
      gnt = GNT_CORE;
    end else if (bus.h_req) begin
      gnt = GNT_HOST;
    end
  end

  assign host_sel     = (gnt == GNT_HOST);
  assign access       = (gnt != GNT_NONE);
  assign sel_we       = host_sel ? bus.h_we    : bus.c_we;
  assign sel_addr     = host_sel ? bus.h_addr  : bus.c_addr;
  assign sel_be       = host_sel ? bus.h_be    : bus.c_be;
  assign sel_wdata    = host_sel ? bus.h_wdata : bus.c_wdata;
  assign sel_addr_ext = 32'(sel_addr);
  assign in_range     = (sel_addr_ext < DEPTH);

  // Out-of-range accesses are acked but never reach the array.
  lram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk (sys_clk),
    .cs  (access && in_range),
    .we  (sel_we),
    .be  (sel_be),
    .a   (sel_addr),
    .d   (sel_wdata),
    .q   (ram_q)
  );

  // The array q is already a register; an out-of-range read is forced to
  // zero via rd_zero, which is captured alongside the read.
  assign rd_word = rd_zero ? '0 : ram_q;

  // Starve counter, read-valid pipeline, held read data and sticky oob flag.
  // Held data only updates when a read completes, so rdata keeps its last
  // value between reads and reset cancels any read still in flight.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      starve_cnt <= '0;
      c_rvalid_r <= 1'b0;
      h_rvalid_r <= 1'b0;
      rd_zero    <= 1'b0;
      c_hold     <= '0;
      h_hold     <= '0;
      oob_r      <= 1'b0;
    end else begin
      if (gnt == GNT_CORE && bus.h_req) starve_cnt <= starve_cnt + 1'b1;
      else                              starve_cnt <= '0;

      c_rvalid_r <= (gnt == GNT_CORE) && !bus.c_we;
      h_rvalid_r <= (gnt == GNT_HOST) && !bus.h_we;

      if (access) rd_zero <= !in_range;
      if (c_rvalid_r) c_hold <= rd_word;
      if (h_rvalid_r) h_hold <= rd_word;
      if (access && !in_range) oob_r <= 1'b1;
    end
  end

  assign bus.c_ack    = (gnt == GNT_CORE);
  assign bus.h_ack    = (gnt == GNT_HOST);
  assign bus.c_rvalid = c_rvalid_r;
  assign bus.h_rvalid = h_rvalid_r;
  assign bus.c_rdata  = c_rvalid_r ? rd_word : c_hold;
  assign bus.h_rdata  = h_rvalid_r ? rd_word : h_hold;
  assign bus.h_oe     = {DATA_W{h_rvalid_r}};
  assign bus.oob_err  = oob_r;

endmodule

// File: tb/tb_lram_arb.sv
// tb_lram_arb: directed self-checking bench for lram_arb (DEPTH = 1000 so
// the upper part of the 10-bit address space is out of range).
module tb_lram_arb;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 10;
  localparam int DEPTH      = 1000;
  localparam int STARVE_MAX = 4;

  logic sys_clk = 1'b0;
  logic resetl;

  always #5 sys_clk = ~sys_clk;

  lram_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  lram_arb #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .sys_clk (sys_clk),
    .resetl  (resetl),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] model [0:1023];
  logic [31:0] exp_c_q [$];
  logic [31:0] exp_h_q [$];
  logic [31:0] last_c;
  logic [31:0] last_h;
  logic        exp_oob;
  logic        pend_c;
  logic        pend_h;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [9:0] a);
    if (int'(a) < DEPTH) return model[a];
    return 32'h0;
  endfunction

  task automatic model_write(input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
    if (int'(a) < DEPTH) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
      end
    end
  endtask

  // Checks the registered outputs one cycle after the stimulus cycle.
  task automatic checkOutput(input string tag);
    check({tag, " c_rvalid"}, 32'(bus.c_rvalid), 32'(pend_c));
    check({tag, " h_rvalid"}, 32'(bus.h_rvalid), 32'(pend_h));
    check({tag, " h_oe"}, bus.h_oe, pend_h ? 32'hFFFF_FFFF : 32'h0);
    if (pend_c) last_c = exp_c_q.pop_front();
    if (pend_h) last_h = exp_h_q.pop_front();
    check({tag, " c_rdata"}, bus.c_rdata, last_c);
    check({tag, " h_rdata"}, bus.h_rdata, last_h);
    check({tag, " oob_err"}, 32'(bus.oob_err), 32'(exp_oob));
  endtask

  // One full cycle: drive at the falling edge, check the combinational acks,
  // push expected read data, update the model at the rising edge, then check.
  task automatic applyStimulus(
    input logic cr, input logic cwe, input logic [9:0] ca, input logic [3:0] cbe, input logic [31:0] cwd,
    input logic hr, input logic hwe, input logic [9:0] ha, input logic [3:0] hbe, input logic [31:0] hwd,
    input logic eca, input logic eha, input string tag);
    bus.c_req = cr; bus.c_we = cwe; bus.c_addr = ca; bus.c_be = cbe; bus.c_wdata = cwd;
    bus.h_req = hr; bus.h_we = hwe; bus.h_addr = ha; bus.h_be = hbe; bus.h_wdata = hwd;
    #1;
    check({tag, " c_ack"}, 32'(bus.c_ack), 32'(eca));
    check({tag, " h_ack"}, 32'(bus.h_ack), 32'(eha));
    pend_c = eca && !cwe;
    pend_h = eha && !hwe;
    if (pend_c) exp_c_q.push_back(model_read(ca));
    if (pend_h) exp_h_q.push_back(model_read(ha));
    if ((eca && int'(ca) >= DEPTH) || (eha && int'(ha) >= DEPTH)) exp_oob = 1'b1;
    @(posedge sys_clk);
    if (eca && cwe) model_write(ca, cbe, cwd);
    if (eha && hwe) model_write(ha, hbe, hwd);
    @(negedge sys_clk);
    checkOutput(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(0, 0, 10'h0, 4'h0, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0, 0, 0, tag);
  endtask

  task automatic core_op(input logic we, input logic [9:0] a, input logic [3:0] be, input logic [31:0] d, input string tag);
    applyStimulus(1, we, a, be, d, 0, 0, 10'h0, 4'h0, 32'h0, 1, 0, tag);
  endtask

  task automatic host_op(input logic we, input logic [9:0] a, input logic [3:0] be, input logic [31:0] d, input string tag);
    applyStimulus(0, 0, 10'h0, 4'h0, 32'h0, 1, we, a, be, d, 0, 1, tag);
  endtask

  task automatic clear_state();
    exp_c_q.delete();
    exp_h_q.delete();
    last_c  = 32'h0;
    last_h  = 32'h0;
    exp_oob = 1'b0;
    pend_c  = 1'b0;
    pend_h  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " c_ack"}, 32'(bus.c_ack), 32'h0);
    check({tag, " h_ack"}, 32'(bus.h_ack), 32'h0);
    check({tag, " c_rvalid"}, 32'(bus.c_rvalid), 32'h0);
    check({tag, " h_rvalid"}, 32'(bus.h_rvalid), 32'h0);
    check({tag, " c_rdata"}, bus.c_rdata, 32'h0);
    check({tag, " h_rdata"}, bus.h_rdata, 32'h0);
    check({tag, " h_oe"}, bus.h_oe, 32'h0);
    check({tag, " oob_err"}, 32'(bus.oob_err), 32'h0);
  endtask

  task automatic do_reset(input string tag);
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_be = '0; bus.c_wdata = '0;
    bus.h_req = 0; bus.h_we = 0; bus.h_addr = '0; bus.h_be = '0; bus.h_wdata = '0;
    resetl = 1'b0;
    clear_state();
    #1;
    check_all_zero(tag);
    @(negedge sys_clk);
    @(negedge sys_clk);
    resetl = 1'b1;
  endtask

  initial begin
    $display("[TB] lram_arb bench start");
    do_reset("reset");

    // Full-word core write and read back, then hold check.
    core_op(1, 10'h005, 4'hF, 32'hDEAD_BEEF, "c_wr");
    core_op(0, 10'h005, 4'h0, 32'h0, "c_rd");
    idle("c_hold");
    // be = 0 write must ack but change nothing.
    core_op(1, 10'h005, 4'h0, 32'h0000_0000, "c_wr_be0");
    core_op(0, 10'h005, 4'h0, 32'h0, "c_rd_be0");
    idle("c_idle");

    // Host single-lane write over an existing word.
    host_op(1, 10'h010, 4'hF, 32'h1122_3344, "h_wr");
    host_op(1, 10'h010, 4'b0010, 32'h0000_AB00, "h_wr_lane1");
    host_op(0, 10'h010, 4'h0, 32'h0, "h_rd");
    idle("h_hold");

    // Both ports requesting continuously: C,C,C,C,H repeating.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 10'h005, 4'h0, 32'h0, 1, 0, 10'h010, 4'h0, 32'h0,
                    (i % 5) != 4, (i % 5) == 4, $sformatf("arb%0d", i));
    end
    idle("arb_end");

    // Back-to-back write then read of the same address from the other port.
    host_op(1, 10'h020, 4'hF, 32'hCAFE_F00D, "x_h_wr");
    core_op(0, 10'h020, 4'h0, 32'h0, "x_c_rd");
    core_op(1, 10'h021, 4'hF, 32'h0BAD_C0DE, "x_c_wr");
    host_op(0, 10'h021, 4'h0, 32'h0, "x_h_rd");
    idle("x_end");

    // Reset right after a host read ack: the read must be cancelled.
    bus.c_req = 0;
    bus.h_req = 1; bus.h_we = 0; bus.h_addr = 10'h010; bus.h_be = 4'h0; bus.h_wdata = 32'h0;
    #1;
    check("mid_rst h_ack", 32'(bus.h_ack), 32'h1);
    @(posedge sys_clk);
    #1;
    resetl = 1'b0;
    bus.h_req = 0;
    clear_state();
    #1;
    check_all_zero("mid_rst");
    @(negedge sys_clk);
    check("mid_rst2 h_rvalid", 32'(bus.h_rvalid), 32'h0);
    @(negedge sys_clk);
    resetl = 1'b1;
    idle("post_rst");

    // Memory contents survive reset.
    core_op(0, 10'h005, 4'h0, 32'h0, "keep_c");
    host_op(0, 10'h010, 4'h0, 32'h0, "keep_h");
    idle("keep_end");

    // Out-of-range accesses: acked, zero data, sticky error flag.
    core_op(0, 10'h3F0, 4'h0, 32'h0, "oob_rd");
    host_op(1, 10'h3E8, 4'hF, 32'hFFFF_FFFF, "oob_wr");
    host_op(0, 10'h3E8, 4'h0, 32'h0, "oob_rd_h");
    core_op(0, 10'h3E7, 4'h0, 32'h0, "edge_rd");
    idle("oob_stick1");
    idle("oob_stick2");
    do_reset("oob_clear");
    idle("oob_after");

    check("sb_drain", 32'(exp_c_q.size() + exp_h_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
